// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall scheduler: merges load-use, execute and multi-cycle op stalls.
// Optional macro PIPE_STALL_PERF_EN enables the saturating stalled-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic               mc_start_i,
  input  logic [CNT_W-1:0]   mc_cycles_i,
  input  logic               mc_annul_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               mc_busy_o,
  output logic               mc_done_o,
  output logic [31:0]        stall_cnt_o
);

  localparam logic [STALL_W-1:0] EX_HOLD_MASK = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] ID_HOLD_MASK = STALL_W'(6'b000111);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;
  logic             ex_hold_c;

  // Next-state and counter sequencing; annul outranks start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mc_start_i && !mc_annul_i) begin
          if (mc_cycles_i != '0) begin
            state_d = ST_BUSY;
            cnt_d   = mc_cycles_i;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (mc_annul_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_BUSY);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign mc_busy_o = busy_q;
  assign mc_done_o = done_q;

  // Zero-latency stall merge; execute hold dominates the decode bubble.
  assign ex_hold_c = stallreq_from_ex || (state_q == ST_BUSY) ||
                     ((state_q == ST_IDLE) && mc_start_i && !mc_annul_i);

  always_comb begin
    stall_o = '0;
    if (!rst) begin
      if (ex_hold_c)             stall_o = EX_HOLD_MASK;
      else if (stallreq_from_id) stall_o = ID_HOLD_MASK;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else if (stall_o[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule
